// File: rtl/ixu_pkg.sv
// Shared widths and pipeline-entry types for the integer execute forwarding slice.
package ixu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
    logic            is_load;
  } ixu_stage_t;

  typedef struct packed {
    logic            sel;
    logic [XLEN-1:0] data;
  } ixu_fwd_t;

endpackage

// File: rtl/ixu_fwd_select.sv
// Three-level forwarding priority match for one source operand; youngest producer wins.
module ixu_fwd_select
  import ixu_pkg::*;
(
  input  logic [RA_W-1:0] rs,
  input  logic            used,
  input  logic            ex_ok,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            m_valid,
  input  logic [RA_W-1:0] m_rd,
  input  logic [XLEN-1:0] m_data,
  input  logic            w_valid,
  input  logic [RA_W-1:0] w_rd,
  input  logic [XLEN-1:0] w_data,
  output ixu_fwd_t        fwd
);

  always_comb begin
    fwd = '0;
    if (used) begin
      if (ex_ok && (ex_rd == rs)) begin
        fwd.sel  = 1'b1;
        fwd.data = ex_data;
      end else if (m_valid && (m_rd == rs)) begin
        fwd.sel  = 1'b1;
        fwd.data = m_data;
      end else if (w_valid && (w_rd == rs)) begin
        fwd.sel  = 1'b1;
        fwd.data = w_data;
      end
    end
  end

endmodule

// File: rtl/ixu_fwd_unit.sv
// Per-slot M/W result history, registered operand forwarding, load-use stall and writeback port.
module ixu_fwd_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_is_nop,
  input  logic            ex_is_load,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic            flush,
  output logic            stall,
  output logic            is_rs1_fwd,
  output logic            is_rs2_fwd,
  output logic [XLEN-1:0] rs1_fwd_data,
  output logic [XLEN-1:0] rs2_fwd_data,
  output logic            wb_valid,
  output logic [RA_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data
);

  import ixu_pkg::*;

  ixu_stage_t      m_q;
  logic            w_valid_q;
  logic [RA_W-1:0] w_rd_q;
  logic [XLEN-1:0] w_data_q;
  ixu_fwd_t        f1_q, f2_q, f1_c, f2_c;

  logic            ex_qual, ex_alu;
  logic [XLEN-1:0] m_data;

  assign ex_qual = ex_valid & ~ex_is_nop & (ex_rd != '0);
  assign ex_alu  = ex_qual & ~ex_is_load;
  // A load in M resolves to the memory data arriving this cycle.
  assign m_data  = m_q.is_load ? mem_load_data : m_q.data;

  assign stall = ~flush & ex_qual & ex_is_load &
                 ((id_rs1_used & (ex_rd == id_rs1)) | (id_rs2_used & (ex_rd == id_rs2)));

  ixu_fwd_select u_sel_rs1 (
    .rs      (id_rs1),
    .used    (id_rs1_used),
    .ex_ok   (ex_alu),
    .ex_rd   (ex_rd),
    .ex_data (ex_result),
    .m_valid (m_q.valid),
    .m_rd    (m_q.rd),
    .m_data  (m_data),
    .w_valid (w_valid_q),
    .w_rd    (w_rd_q),
    .w_data  (w_data_q),
    .fwd     (f1_c)
  );

  ixu_fwd_select u_sel_rs2 (
    .rs      (id_rs2),
    .used    (id_rs2_used),
    .ex_ok   (ex_alu),
    .ex_rd   (ex_rd),
    .ex_data (ex_result),
    .m_valid (m_q.valid),
    .m_rd    (m_q.rd),
    .m_data  (m_data),
    .w_valid (w_valid_q),
    .w_rd    (w_rd_q),
    .w_data  (w_data_q),
    .fwd     (f2_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      w_valid_q <= 1'b0;
      w_rd_q    <= '0;
      w_data_q  <= '0;
      f1_q      <= '0;
      f2_q      <= '0;
    end else if (flush) begin
      m_q       <= '0;
      w_valid_q <= 1'b0;
      w_rd_q    <= '0;
      w_data_q  <= '0;
      f1_q      <= '0;
      f2_q      <= '0;
    end else begin
      m_q.valid   <= ex_qual;
      m_q.rd      <= ex_rd;
      m_q.data    <= ex_result;
      m_q.is_load <= ex_is_load;
      w_valid_q   <= m_q.valid;
      w_rd_q      <= m_q.rd;
      w_data_q    <= m_data;
      // A stalled consumer enters EX as a bubble with no forwarding.
      f1_q        <= stall ? '0 : f1_c;
      f2_q        <= stall ? '0 : f2_c;
    end
  end

  assign is_rs1_fwd   = f1_q.sel;
  assign rs1_fwd_data = f1_q.data;
  assign is_rs2_fwd   = f2_q.sel;
  assign rs2_fwd_data = f2_q.data;
  assign wb_valid     = w_valid_q;
  assign wb_rd        = w_rd_q;
  assign wb_data      = w_data_q;

endmodule

// File: tb/tb_ixu_fwd_unit.sv
// Scoreboard bench for ixu_fwd_unit: directed scenarios then randomized traffic vs. a history-list model.
module tb_ixu_fwd_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_nop, ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result, mem_load_data;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_rs1_used, id_rs2_used, flush;
  logic        stall, is_rs1_fwd, is_rs2_fwd, wb_valid;
  logic [31:0] rs1_fwd_data, rs2_fwd_data, wb_data;
  logic [4:0]  wb_rd;

  ixu_fwd_unit #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_nop(ex_is_nop),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_load_data(mem_load_data), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .flush(flush),
    .stall(stall), .is_rs1_fwd(is_rs1_fwd), .is_rs2_fwd(is_rs2_fwd),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        f1s;
    logic [31:0] f1d;
    logic        f2s;
    logic [31:0] f2d;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
  } exp_t;

  // One retired producer; hist[0] is the instruction now in M, hist[1] the one in W.
  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        ld;
  } ent_t;

  exp_t        expq[$];
  ent_t        hist[2];
  logic        mf1s, mf2s;
  logic [31:0] mf1d, mf2d;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("stall", {31'b0, stall}, {31'b0, e.stall});
      chk("is_rs1_fwd", {31'b0, is_rs1_fwd}, {31'b0, e.f1s});
      chk("rs1_fwd_data", rs1_fwd_data, e.f1d);
      chk("is_rs2_fwd", {31'b0, is_rs2_fwd}, {31'b0, e.f2s});
      chk("rs2_fwd_data", rs2_fwd_data, e.f2d);
      chk("wb_valid", {31'b0, wb_valid}, {31'b0, e.wbv});
      chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.wbrd});
      chk("wb_data", wb_data, e.wbd);
    end
  end

  function automatic logic [32:0] find(input logic [4:0] rs, input logic used, input ent_t ex);
    ent_t c[3];
    c[0] = ex;
    c[1] = hist[0];
    c[2] = hist[1];
    if (!used) return '0;
    for (int i = 0; i < 3; i++)
      if (c[i].v && c[i].rd == rs) return {1'b1, c[i].val};
    return '0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 2; i++) hist[i] = '{v: 1'b0, rd: 5'd0, val: 32'd0, ld: 1'b0};
    mf1s = 1'b0; mf1d = '0; mf2s = 1'b0; mf2d = '0;
  endtask

  task automatic cyc(input logic rst, input logic v, input logic nop, input logic ld,
                     input logic [4:0] rd, input logic [31:0] res, input logic [31:0] ldd,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2, input logic fl);
    exp_t        e;
    ent_t        exe;
    logic        q, st;
    logic [32:0] a, b;
    @(posedge clk);
    #1;
    rst_n = rst; ex_valid = v; ex_is_nop = nop; ex_is_load = ld; ex_rd = rd;
    ex_result = res; mem_load_data = ldd; id_rs1 = r1; id_rs2 = r2;
    id_rs1_used = u1; id_rs2_used = u2; flush = fl;
    if (!rst) clear_model();
    if (hist[0].ld) hist[0].val = ldd;
    q  = v && !nop && rd != 0;
    st = !fl && q && ld && ((u1 && r1 == rd) || (u2 && r2 == rd));
    e = '{stall: st, f1s: mf1s, f1d: mf1d, f2s: mf2s, f2d: mf2d,
          wbv: hist[1].v, wbrd: hist[1].rd, wbd: hist[1].val};
    expq.push_back(e);
    if (rst) begin
      if (fl) clear_model();
      else begin
        exe = '{v: q && !ld, rd: rd, val: res, ld: ld};
        a = find(r1, u1, exe);
        b = find(r2, u2, exe);
        if (st) begin a = '0; b = '0; end
        {mf1s, mf1d} = a;
        {mf2s, mf2d} = b;
        hist[1] = hist[0];
        hist[0] = '{v: q, rd: rd, val: res, ld: ld};
      end
    end
  endtask

  task automatic idle(input logic [31:0] ldd);
    cyc(1, 0, 0, 0, 0, 0, ldd, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 0; ex_is_nop = 0; ex_is_load = 0; ex_rd = 0;
    ex_result = 0; mem_load_data = 0; id_rs1 = 0; id_rs2 = 0;
    id_rs1_used = 0; id_rs2_used = 0; flush = 0;
    clear_model();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    // back-to-back ALU
    cyc(1, 1, 0, 0, 5, 32'h10, 0, 5, 0, 1, 0, 0);
    idle(0); idle(0); idle(0);
    // EX beats M
    cyc(1, 1, 0, 0, 7, 32'h11, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 7, 32'h22, 0, 0, 7, 0, 1, 0);
    idle(0); idle(0); idle(0);
    // load-use: stall, then M supplies load data, then writeback
    cyc(1, 1, 0, 1, 3, 32'hDEAD_BEEF, 0, 3, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 3, 0, 1, 0, 0);
    idle(0); idle(0); idle(0);
    // x0, NOP, unused operand
    cyc(1, 1, 0, 0, 0, 32'h55, 0, 0, 0, 1, 0, 0);
    idle(0); idle(0);
    cyc(1, 1, 1, 0, 4, 32'h44, 0, 4, 4, 1, 1, 0);
    idle(0); idle(0);
    cyc(1, 1, 0, 1, 6, 32'h66, 0, 0, 6, 0, 0, 0);
    idle(32'h1234_5678); idle(0); idle(0);
    // flush with M, W valid and a pending load match
    cyc(1, 1, 0, 0, 8, 32'h88, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 9, 32'h99, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 10, 32'hA0, 0, 10, 9, 1, 1, 1);
    idle(0); idle(0);
    // asynchronous reset mid-stream with W valid
    cyc(1, 1, 0, 0, 12, 32'hC0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 13, 32'hD0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 14, 32'hE0, 0, 13, 12, 1, 1, 0);
    cyc(0, 1, 0, 0, 15, 32'hF0, 0, 14, 13, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 14, 13, 1, 1, 0);
    idle(0); idle(0);
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
          5'($urandom_range(0, 7)), $urandom(), $urandom(),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 19) == 0));
    end
    @(negedge clk);
    #1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending expected=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ixu_fwd_unit.md
Name: ixu_fwd_unit

Overview:
- Producer-side counterpart of the integer execute stage.
- Tracks in-flight IXU results after EX: the EX→MEM (M) and MEM→WB (W) history.
- Generates the registered forwarding selects and data (is_rs1_fwd/rs1_fwd_data, is_rs2_fwd/rs2_fwd_data) the execute stage consumes, plus a load-use stall and the writeback port.
- One instance per integer issue slot of the VLIW bundle.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX slot holds a real instruction this cycle.
- ex_is_nop  in  1  EX instruction is a NOP (never produces a result).
- ex_is_load  in  1  EX instruction is a load; its result is not available until M.
- ex_rd  in  RA_W  EX destination register.
- ex_result  in  XLEN  EX ALU output.
- mem_load_data  in  XLEN  load data; valid in the cycle a load occupies M.
- id_rs1, id_rs2  in  RA_W  source registers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  source operand is actually read.
- flush  in  1  synchronous pipeline flush.
- stall  out  1  combinational load-use stall request to ID/IF.
- is_rs1_fwd, is_rs2_fwd  out  1  registered forward selects, aligned to EX.
- rs1_fwd_data, rs2_fwd_data  out  XLEN  registered forward data, aligned to EX.
- wb_valid  out  1  register-file write enable.
- wb_rd  out  RA_W  write address.
- wb_data  out  XLEN  write data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - M and W entries invalid, rd=0, data=0.
  - All forward outputs and wb_* are 0.
- Qualifying producer: valid & ~nop & rd≠0. x0 is never forwarded or written.
- Each rising edge, with no flush:
  - M ← {ex qualifying, ex_rd, ex_result, ex_is_load}.
  - W ← {M.valid, M.rd, M.is_load ? mem_load_data : M.data}.
- wb_valid/wb_rd/wb_data are driven directly from the W entry. The register file writes on the following edge.
- Forwarding is computed in ID and registered at the edge, so it appears while the consumer is in EX. Per source s, only when id_rs_s_used:
  - Priority 1: EX qualifying, ~ex_is_load, ex_rd==rs → ex_result.
  - Priority 2: else M.valid, M.rd==rs → M.is_load ? mem_load_data : M.data.
  - Priority 3: else W.valid, W.rd==rs → W.data.
  - Otherwise is_rs_fwd=0 and data=0.
  - The youngest producer always wins.
- stall = id_valid operand match on an EX qualifying load, i.e. (id_rs1_used & rs1 match) | (id_rs2_used & rs2 match), combinational.
  - On a stall edge, the forward registers load 0 (bubble entering EX).
  - The M/W pipeline still advances.
  - Next cycle the load sits in M and priority 2 supplies mem_load_data: exactly one bubble.
- flush (synchronous; reset has priority):
  - M, W and the forward registers are cleared to invalid/0 at the edge.
  - stall is forced 0 while flush is high.
  - wb_valid is 0 on the cycle after the flush.
- Identical rs1/rs2 are handled independently; both may forward the same value.
- Latency: EX result visible to the next consumer with 0 bubbles (ALU) or 1 bubble (load). Writeback occurs 2 edges after EX.
- No internal state beyond M, W and the two forward registers. Counters and FSMs are not required.

Decomposition:
- ixu_pkg holds:
  - XLEN and RA_W constants.
  - Typedef ixu_stage_t {logic valid; logic [RA_W-1:0] rd; logic [XLEN-1:0] data; logic is_load}.
  - Typedef ixu_fwd_t {logic sel; logic [XLEN-1:0] data}.
- One sub-module, ixu_fwd_select: the combinational 3-level priority match for one source operand. Instantiate it twice (rs1, rs2).

Test Plan:
- Reset: hold rst_n=0 mid-stream with W valid → all outputs 0 immediately; after release, no forwarding until a new producer arrives.
- Back-to-back ALU: EX ADD rd=5 result 0x0000_0010, ID reads rs1=5 → next cycle is_rs1_fwd=1, rs1_fwd_data=0x10, stall=0.
- Priority: M holds rd=7 data 0x11; EX rd=7 result 0x22; ID rs2=7 → rs2_fwd_data=0x22 (EX beats M).
- Load-use: EX load rd=3, ID rs1=3 → stall=1 for one cycle with forward registers 0. Next cycle, with mem_load_data=0xCAFE_F00D → is_rs1_fwd=1, data=0xCAFEF00D. Two edges after the load left EX → wb_valid=1, wb_rd=3, wb_data=0xCAFEF00D.
- x0/NOP/unused:
  - EX rd=0 result 0x55 with ID rs1=0 → no forward, no wb.
  - ex_is_nop=1 with rd=4 → no forward.
  - id_rs2_used=0 with a match → is_rs2_fwd=0 and no stall.
- Flush: M, W valid and a pending load match; flush=1 → stall=0 that cycle. Next cycle all is_rs*_fwd=0 and wb_valid=0.
